// File: rtl/channel_pkg.sv
// Shared types and constants for the channel DMA datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package channel_pkg;

    localparam int         BYTE_LANES  = 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RD_EMIT,
        ST_WR_FILL,
        ST_WR_ISSUE,
        ST_WR_RESP,
        ST_FINISH
    } dma_state_t;

endpackage

// File: rtl/byte_lane_packer.sv
// 64-bit lane register: byte insert with strobe accumulation, whole-word load, byte extract.
// Latency: insert/load/clear take effect on the next clock; extract is combinational.
// Backpressure: none; the caller decides when each operation fires.
module byte_lane_packer
    import channel_pkg::*;
(
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [63:0]             load_data,
    input  logic                    insert,
    input  logic [2:0]              insert_lane,
    input  logic [7:0]              insert_byte,
    input  logic [2:0]              extract_lane,
    output logic [63:0]             data,
    output logic [BYTE_LANES-1:0]   strb,
    output logic [7:0]              extract_byte
);

    // Clear wins over load, load wins over a single-byte insert
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data <= '0;
            strb <= '0;
        end else if (clear) begin
            data <= '0;
            strb <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (insert) begin
            data[{insert_lane, 3'b000} +: 8] <= insert_byte;
            strb[insert_lane]                <= 1'b1;
        end
    end

    assign extract_byte = data[{extract_lane, 3'b000} +: 8];

endmodule

// File: rtl/axi_byte_stream_dma.sv
// Moves bytes between the channel byte streams and memory using single-beat 64-bit AXI-Lite transfers.
// Latency: arvalid at start+1; tx byte 2 cycles after R handshake; aw/w the cycle after the flushing byte.
// Backpressure: tx holds data until tx_tready; rx_tready only in fill; AXI valids held until their ready.
module axi_byte_stream_dma
    import channel_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [7:0]  count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    dma_state_t  state;
    dma_state_t  state_nxt;
    logic [31:0] word_addr;
    logic [2:0]  lane;
    logic [7:0]  remaining;
    logic        aw_done;
    logic        w_done;
    logic [2:0]  extract_lane;
    logic [7:0]  extract_byte;

    // A start landing in the done cycle is dropped so the controller must re-pulse it
    logic start_ok;
    logic r_hs, tx_hs, rx_hs, b_hs, aw_hs, w_hs;
    logic r_err, b_err, rx_flush, last_tx;

    assign start_ok = start && (state == ST_IDLE) && !done;
    assign r_hs     = m_axi_rvalid && m_axi_rready;
    assign tx_hs    = tx_tvalid && tx_tready;
    assign rx_hs    = rx_tvalid && rx_tready;
    assign b_hs     = m_axi_bvalid && m_axi_bready;
    assign aw_hs    = m_axi_awvalid && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign r_err    = (m_axi_rresp != RESP_OKAY);
    assign b_err    = (m_axi_bresp != RESP_OKAY);
    assign rx_flush = rx_hs && ((remaining == 8'd1) || (lane == 3'd7));
    assign last_tx  = tx_hs && (remaining == 8'd1);

    // On an accepted byte the next presented byte comes from the following lane
    assign extract_lane = tx_hs ? (lane + 3'd1) : lane;

    assign m_axi_araddr = word_addr;
    assign m_axi_awaddr = word_addr;

    byte_lane_packer u_packer (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .clear        (start_ok || b_hs),
        .load         (r_hs && !r_err),
        .load_data    (m_axi_rdata),
        .insert       (rx_hs),
        .insert_lane  (lane),
        .insert_byte  (rx_tdata),
        .extract_lane (extract_lane),
        .data         (m_axi_wdata),
        .strb         (m_axi_wstrb),
        .extract_byte (extract_byte)
    );

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    if (count == 8'd0) state_nxt = ST_FINISH;
                    else if (write)    state_nxt = ST_WR_FILL;
                    else               state_nxt = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR:  if (m_axi_arvalid && m_axi_arready) state_nxt = ST_RD_DATA;
            ST_RD_DATA:  if (r_hs) state_nxt = r_err ? ST_FINISH : ST_RD_EMIT;
            ST_RD_EMIT: begin
                if (last_tx)                     state_nxt = ST_FINISH;
                else if (tx_hs && lane == 3'd7)  state_nxt = ST_RD_ADDR;
            end
            ST_WR_FILL:  if (rx_flush) state_nxt = ST_WR_ISSUE;
            ST_WR_ISSUE: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WR_RESP;
            ST_WR_RESP: begin
                if (b_hs) state_nxt = (b_err || remaining == 8'd0) ? ST_FINISH : ST_WR_FILL;
            end
            ST_FINISH:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        busy          = (state != ST_IDLE);
        m_axi_arvalid = (state == ST_RD_ADDR);
        m_axi_rready  = (state == ST_RD_DATA);
        rx_tready     = (state == ST_WR_FILL);
        m_axi_awvalid = (state == ST_WR_ISSUE) && !aw_done;
        m_axi_wvalid  = (state == ST_WR_ISSUE) && !w_done;
        m_axi_bready  = (state == ST_WR_RESP);
    end

    // Address/lane/count bookkeeping, tx output register, error and done flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            word_addr <= '0;
            lane      <= '0;
            remaining <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            tx_tdata  <= '0;
            tx_tvalid <= 1'b0;
            error     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == ST_FINISH);
            if (start_ok) begin
                word_addr <= {addr[31:3], 3'b000};
                lane      <= addr[2:0];
                remaining <= count;
                error     <= 1'b0;
            end
            case (state)
                ST_RD_DATA: begin
                    if (r_hs && r_err) begin
                        error     <= 1'b1;
                        remaining <= '0;
                    end
                end
                ST_RD_EMIT: begin
                    if (!tx_tvalid) begin
                        tx_tvalid <= 1'b1;
                        tx_tdata  <= extract_byte;
                    end else if (tx_tready) begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            tx_tvalid <= 1'b0;
                        end else if (lane == 3'd7) begin
                            tx_tvalid <= 1'b0;
                            lane      <= '0;
                            word_addr <= word_addr + 32'd8;
                        end else begin
                            lane     <= lane + 3'd1;
                            tx_tdata <= extract_byte;
                        end
                    end
                end
                ST_WR_FILL: begin
                    if (rx_hs) begin
                        remaining <= remaining - 8'd1;
                        if (!rx_flush) lane <= lane + 3'd1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                ST_WR_ISSUE: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                ST_WR_RESP: begin
                    if (b_hs) begin
                        lane      <= '0;
                        word_addr <= word_addr + 32'd8;
                        if (b_err) begin
                            error     <= 1'b1;
                            remaining <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
